clk_gate_ctrl: RTL
==================

Name: clk_gate_ctrl

Overview:
Multi-channel clock-gating controller with per-channel activity-driven auto gating and idle hysteresis. Each channel owns a glitch-free latch-based gated clock plus a request/acknowledge handshake. Clients raise a request to get their clock. The controller keeps each channel's clock running for a programmable number of idle cycles after its request drops, then gates it. It sits between the root clock and the leaf blocks of power-managed subsystems. A global test enable bypasses all gating for scan.

Parameters:
NUM_CH, 4, number of independent gated-clock channels (>=1)
IDLE_W, 4, width of the idle-hysteresis counter and of idle_cycles_i

Ports:
clk_i  input  1  root clock
arst_i  input  1  asynchronous, active-high reset
te_i  input  1  test enable; forces every gclk_o to follow clk_i
req_i  input  NUM_CH  per-channel clock request (synchronous to clk_i)
idle_cycles_i  input  IDLE_W  hysteresis length K, shared by all channels
ack_o  output  NUM_CH  per-channel "clock running" acknowledge
gclk_o  output  NUM_CH  per-channel gated clock
active_cnt_o  output  $clog2(NUM_CH+1)  number of channels with ack_o high

Behaviour:
- Reset: asynchronous and active-high. On reset every channel goes to OFF.
  - ack_o=0 and active_cnt_o=0.
  - Enable latches clear asynchronously, so gclk_o=0 whenever te_i=0.
  - A high phase of gclk_o already in progress may be truncated, but only by reset.
- Per-channel state machine: OFF, ON, HOLD. Down counter cnt is IDLE_W bits wide.
  - OFF -> ON when req_i[c]=1 is sampled at a rising edge.
  - ON stays ON while req_i[c]=1.
  - ON with req_i[c]=0 goes to HOLD and loads cnt=idle_cycles_i-1. If idle_cycles_i=0, it goes directly to OFF.
  - HOLD with req_i[c]=1 returns to ON and cnt is ignored.
  - HOLD with cnt=0 goes to OFF. Otherwise cnt decrements.
- idle_cycles_i is sampled only on the ON->HOLD transition. Changes during HOLD are ignored.
- ack_o[c]=1 in ON or HOLD. It is decoded directly from the state register, with no extra flop.
- Enable path: en[c] = (state!=OFF) | te_i.
  - en[c] feeds a latch that is transparent while clk_i is low.
  - gclk_o[c] = clk_i & latch_q[c]. There are no glitches or runt pulses when en changes.
- Wake latency: req_i[c] is sampled high at edge N.
  - ack_o[c] rises just after N.
  - The first gated rising edge is N+1.
  - Rule: ack_o high means the next clk_i rising edge is propagated.
- Sleep latency: req_i[c] is sampled low at edge N while ON, with idle_cycles_i=K.
  - ack_o[c] falls just after edge N+K.
  - The last propagated rising edge is N+K. For K=0 it is N itself.
  - With req held low, exactly K gated edges follow the edge that sampled req low.
- Simultaneous events:
  - req re-asserted in the same cycle that cnt reaches 0 in HOLD: ON wins and the clock is never gated.
  - Channels are fully independent; all may transition in the same cycle.
- te_i:
  - te_i=1 makes every gclk_o equal clk_i, including during reset.
  - te_i does not alter the state machines, ack_o or active_cnt_o.
  - Deasserting te_i is glitch-free through the latch.
- active_cnt_o is the combinational popcount of ack_o. Its range is 0..NUM_CH with no overflow.
- The latch is inferred as a level-sensitive always_latch.

Test Plan:
- Reset check: assert arst_i mid-cycle while all channels are ON -> ack_o=0 and active_cnt_o=0 immediately, and gclk_o=0 from then on with te_i=0.
- Wake handshake: req_i[0] sampled at edge 10 -> ack_o[0]=1 after edge 10; first gclk_o[0] rising edge coincides with clk_i edge 11; other channels stay 0.
- Hysteresis: idle_cycles_i=3, req_i[1] drops sampled at edge 20 -> gclk_o[1] pulses at edges 21, 22 and 23; ack_o[1] falls after 23; no pulse at 24. Repeat with idle_cycles_i=0 -> last pulse at edge 20.
- Re-request in HOLD: idle_cycles_i=5, req drops at edge 30 and re-asserts sampled at edge 32 -> ack stays 1 and there is no missing gclk edge. Then drop req again -> a full 5-edge hold restarts.
- Test bypass: all req_i=0 with te_i=1 -> every gclk_o equals clk_i; ack_o=0 and active_cnt_o=0. Drop te_i while clk_i is high -> gclk_o completes its high phase, then stays low.
- Random regression: 2000 cycles of random req_i, idle_cycles_i and te_i, checked against a cycle-accurate model of the state machine, with an assertion that gclk_o never rises unless clk_i rises -> zero mismatches and active_cnt_o always equal to popcount(ack_o).

Source files
------------

// File: rtl/clk_gate_ctrl.sv
// Multi-channel clock-gating controller.
// Each channel runs a small OFF/ON/HOLD state machine driven by its request.
// A channel keeps its clock running for a programmable number of idle cycles
// after the request drops, then gates it. Every gated clock is produced by a
// latch that is transparent while clk_i is low, so enable changes cannot
// create glitches or runt pulses. te_i bypasses gating for scan.
module clk_gate_ctrl #(
    parameter int NUM_CH = 4,
    parameter int IDLE_W = 4
) (
    input  logic                             clk_i,
    input  logic                             arst_i,
    input  logic                             te_i,
    input  logic [NUM_CH-1:0]                req_i,
    input  logic [IDLE_W-1:0]                idle_cycles_i,
    output logic [NUM_CH-1:0]                ack_o,
    output logic [NUM_CH-1:0]                gclk_o,
    output logic [$clog2(NUM_CH+1)-1:0]      active_cnt_o
);

    localparam int CNT_W = $clog2(NUM_CH + 1);

    localparam logic [1:0] ST_OFF  = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [1:0]        state_q;
            logic [1:0]        state_d;
            logic [IDLE_W-1:0] cnt_q;
            logic [IDLE_W-1:0] cnt_d;
            logic              en;
            logic              latch_q;

            // Next-state logic: request wins over an expiring hold counter,
            // and the hold length is captured only when leaving ON.
            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                case (state_q)
                    ST_OFF: begin
                        if (req_i[gi]) begin
                            state_d = ST_ON;
                        end
                    end
                    ST_ON: begin
                        if (!req_i[gi]) begin
                            if (idle_cycles_i == '0) begin
                                state_d = ST_OFF;
                            end else begin
                                state_d = ST_HOLD;
                                cnt_d   = idle_cycles_i - IDLE_W'(1);
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (req_i[gi]) begin
                            state_d = ST_ON;
                        end else if (cnt_q == '0) begin
                            state_d = ST_OFF;
                        end else begin
                            cnt_d = cnt_q - IDLE_W'(1);
                        end
                    end
                    default: begin
                        state_d = ST_OFF;
                    end
                endcase
            end

            // State and hold counter registers, cleared by the async reset.
            always_ff @(posedge clk_i or posedge arst_i) begin
                if (arst_i) begin
                    state_q <= ST_OFF;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            // Acknowledge is a pure decode of the state register.
            assign ack_o[gi] = (state_q != ST_OFF);
            assign en        = ack_o[gi] | te_i;

            // Enable latch: open while clk_i is low; reset may cut a high
            // phase short unless test mode is holding the clock on.
            always_latch begin
                if (!clk_i) begin
                    latch_q <= en;
                end else if (arst_i && !te_i) begin
                    latch_q <= 1'b0;
                end
            end

            assign gclk_o[gi] = clk_i & latch_q;
        end
    endgenerate

    // Popcount of running channels; width covers 0..NUM_CH.
    always_comb begin
        active_cnt_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            active_cnt_o = active_cnt_o + CNT_W'(ack_o[i]);
        end
    end

endmodule
